fifo: RTL and testbench

// - Synchronous single-clock FIFO with a valid/ready-style push/pop interface and full/empty flags.
// - Buffers WIDTH-bit words between a producer (w_valid/data_in) and a consumer (r_ready/data_out).
// - First-word-fall-through (show-ahead): the head word is on data_out whenever the FIFO is non-empty.
// - Used as a generic elastic buffer inside the SoC datapath.

---
 rtl/fifo_mem.sv | 26 ++
 rtl/fifo.sv | 80 ++++++++
 tb/tb_fifo.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/fifo_mem.sv
// rtl/fifo_mem.sv - WIDTH x DEPTH register array, one synchronous write port, one asynchronous read port
module fifo_mem #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 3,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Storage is deliberately not reset; the pointers and count decide what is valid.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fifo.sv
// rtl/fifo.sv - single-clock show-ahead FIFO with valid/ready push/pop and full/empty flags
module fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             w_valid,
    input  logic [WIDTH-1:0] data_in,
    input  logic             r_ready,
    output logic [WIDTH-1:0] data_out,
    output logic             fifo_full,
    output logic             fifo_empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [AW-1:0] PTR_LAST  = AW'(DEPTH - 1);
    localparam logic [CW-1:0] CNT_FULL  = CW'(DEPTH);

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push_en, pop_en;
    logic [WIDTH-1:0] head_data;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CNT_FULL);

    // When full, a push only fits if the head leaves in the same cycle.
    assign pop_en  = r_ready & ~fifo_empty;
    assign push_en = w_valid & (~fifo_full | pop_en);

    // Next-state for pointers (explicit wrap, DEPTH need not be a power of two) and occupancy.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_en) begin
            wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + AW'(1);
        end
        if (pop_en) begin
            rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + AW'(1);
        end
        if (push_en && !pop_en) begin
            count_d = count_q + CW'(1);
        end else if (pop_en && !push_en) begin
            count_d = count_q - CW'(1);
        end
    end

    // Pointer and count registers; reset discards every stored word.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk     (clk),
        .we_i    (push_en),
        .waddr_i (wr_ptr_q),
        .wdata_i (data_in),
        .raddr_i (rd_ptr_q),
        .rdata_o (head_data)
    );

    assign data_out = fifo_empty ? '0 : head_data;

endmodule

// File: tb/tb_fifo.sv
// tb/tb_fifo.sv - self-checking bench for fifo (directed table, corner sequences, random scoreboard)
module tb_fifo;

    localparam int WIDTH = 32;
    localparam int DEPTH = 3;

    logic             clk;
    logic             reset;
    logic             w_valid;
    logic [WIDTH-1:0] data_in;
    logic             r_ready;
    logic [WIDTH-1:0] data_out;
    logic             fifo_full;
    logic             fifo_empty;

    int checks = 0;
    int errors = 0;

    fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .w_valid    (w_valid),
        .data_in    (data_in),
        .r_ready    (r_ready),
        .data_out   (data_out),
        .fifo_full  (fifo_full),
        .fifo_empty (fifo_empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic             rst_n;
        logic             wv;
        logic [WIDTH-1:0] din;
        logic             rr;
        logic [WIDTH-1:0] exp_dout;
        logic             exp_full;
        logic             exp_empty;
    } vec_t;

    vec_t vecs [17];

    task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step(input logic rst_n, input logic wv, input logic [WIDTH-1:0] din, input logic rr);
        @(negedge clk);
        reset   = rst_n;
        w_valid = wv;
        data_in = din;
        r_ready = rr;
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string name, input logic [WIDTH-1:0] d, input logic f, input logic e);
        check({name, ".data_out"}, data_out, d);
        check({name, ".full"}, WIDTH'(fifo_full), WIDTH'(f));
        check({name, ".empty"}, WIDTH'(fifo_empty), WIDTH'(e));
    endtask

    logic [WIDTH-1:0] model_q [$];
    logic             rw, rr_b;
    logic [WIDTH-1:0] rd;
    logic             m_pop, m_push;
    logic [WIDTH-1:0] m_head;

    initial begin
        reset = 1'b1; w_valid = 1'b0; data_in = '0; r_ready = 1'b0;

        //            rst  wv  din          rr   dout         full empty
        vecs[0]  = '{1'b0, 1'b0, 32'h0,     1'b0, 32'h0,      1'b0, 1'b1}; // reset
        vecs[1]  = '{1'b1, 1'b1, 32'hA0,    1'b0, 32'hA0,     1'b0, 1'b0}; // fill 1
        vecs[2]  = '{1'b1, 1'b1, 32'hA1,    1'b0, 32'hA0,     1'b0, 1'b0}; // fill 2
        vecs[3]  = '{1'b1, 1'b1, 32'hA2,    1'b0, 32'hA0,     1'b1, 1'b0}; // fill 3 -> full
        vecs[4]  = '{1'b1, 1'b1, 32'hA3,    1'b0, 32'hA0,     1'b1, 1'b0}; // overflow dropped
        vecs[5]  = '{1'b1, 1'b0, 32'h0,     1'b1, 32'hA1,     1'b0, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, 32'h0,     1'b1, 32'hA2,     1'b0, 1'b0};
        vecs[7]  = '{1'b1, 1'b0, 32'h0,     1'b1, 32'h0,      1'b0, 1'b1};
        vecs[8]  = '{1'b1, 1'b0, 32'h0,     1'b1, 32'h0,      1'b0, 1'b1}; // underflow
        vecs[9]  = '{1'b1, 1'b0, 32'h0,     1'b1, 32'h0,      1'b0, 1'b1}; // underflow
        vecs[10] = '{1'b1, 1'b1, 32'hB0,    1'b1, 32'hB0,     1'b0, 1'b0}; // push+pop empty
        vecs[11] = '{1'b1, 1'b1, 32'hB1,    1'b0, 32'hB0,     1'b0, 1'b0};
        vecs[12] = '{1'b1, 1'b1, 32'hB2,    1'b0, 32'hB0,     1'b1, 1'b0};
        vecs[13] = '{1'b1, 1'b1, 32'h55,    1'b1, 32'hB1,     1'b1, 1'b0}; // full push+pop
        vecs[14] = '{1'b1, 1'b0, 32'h0,     1'b1, 32'hB2,     1'b0, 1'b0};
        vecs[15] = '{1'b1, 1'b0, 32'h0,     1'b1, 32'h55,     1'b0, 1'b0};
        vecs[16] = '{1'b1, 1'b0, 32'h0,     1'b1, 32'h0,      1'b0, 1'b1};

        for (int i = 0; i < 17; i++) begin
            step(vecs[i].rst_n, vecs[i].wv, vecs[i].din, vecs[i].rr);
            check_out($sformatf("vec%0d", i), vecs[i].exp_dout, vecs[i].exp_full, vecs[i].exp_empty);
        end

        // Wrap with steady push+pop: occupancy stays at two, order preserved.
        step(1'b0, 1'b0, '0, 1'b0);
        step(1'b1, 1'b1, 32'hC0, 1'b0);
        step(1'b1, 1'b1, 32'hC1, 1'b0);
        check_out("wrap.pre", 32'hC0, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            step(1'b1, 1'b1, 32'hC2 + WIDTH'(k), 1'b1);
            check_out($sformatf("wrap%0d", k), 32'hC1 + WIDTH'(k), 1'b0, 1'b0);
        end
        step(1'b1, 1'b0, '0, 1'b1);
        check_out("wrap.drain1", 32'hC6, 1'b0, 1'b0);
        step(1'b1, 1'b0, '0, 1'b1);
        check_out("wrap.drain2", 32'h0, 1'b0, 1'b1);

        // Reset mid-operation discards contents.
        step(1'b1, 1'b1, 32'hD0, 1'b0);
        step(1'b1, 1'b1, 32'hD1, 1'b0);
        step(1'b0, 1'b1, 32'hD2, 1'b0);
        check_out("midrst", 32'h0, 1'b0, 1'b1);
        step(1'b1, 1'b1, 32'hE0, 1'b0);
        check_out("post_rst", 32'hE0, 1'b0, 1'b0);
        step(1'b1, 1'b0, '0, 1'b1);
        check_out("post_rst.pop", 32'h0, 1'b0, 1'b1);

        // Random traffic against a queue model.
        model_q.delete();
        for (int c = 0; c < 1200; c++) begin
            rw   = 1'($urandom_range(0, 1));
            rr_b = 1'($urandom_range(0, 1));
            rd   = $urandom;
            m_pop  = rr_b && (model_q.size() > 0);
            m_push = rw && ((model_q.size() < DEPTH) || m_pop);
            if (m_pop)  void'(model_q.pop_front());
            if (m_push) model_q.push_back(rd);
            step(1'b1, rw, rd, rr_b);
            m_head = (model_q.size() > 0) ? model_q[0] : '0;
            checks++;
            if (data_out !== m_head || fifo_full !== (model_q.size() == DEPTH)
                || fifo_empty !== (model_q.size() == 0)) begin
                errors++;
                $display("FAIL rand%0d: got data=0x%0h full=%0b empty=%0b expected data=0x%0h full=%0b empty=%0b",
                         c, data_out, fifo_full, fifo_empty, m_head,
                         model_q.size() == DEPTH, model_q.size() == 0);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
